// File: rtl/bcd_timer_scan.sv
// N-digit BCD up/down timer with load/start/pause, stop-or-wrap at terminal count,
// and a multiplexed active-low 7-segment scan driver, all on the clk1k domain.
module bcd_timer_scan #(
  parameter int DIGITS   = 6,
  parameter int TICK_DIV = 1,
  parameter int SCAN_DIV = 1,
  parameter int BLANK_LZ = 1
) (
  input  logic                  rst,
  input  logic                  clk1k,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  up,
  input  logic                  wrap,
  output logic [4*DIGITS-1:0]   value,
  output logic                  running,
  output logic                  done,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [TW-1:0]         tick_cnt;
  logic [SW-1:0]         scan_cnt;
  logic [IW-1:0]         scan_idx;
  logic [4*DIGITS-1:0]   clamped;
  logic [4*DIGITS-1:0]   stepped;
  logic [4*DIGITS-1:0]   term;
  logic                  at_term;
  logic                  carry;
  logic [3:0]            dig;

  // Clamp the load value and compute the one-step BCD neighbour in the current direction.
  always_comb begin
    clamped = load_val;
    stepped = value;
    carry   = 1'b1;
    dig     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) clamped[4*i +: 4] = 4'd9;
      dig = value[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (dig == 4'd9) dig = 4'd0;
          else begin
            dig   = dig + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig == 4'd0) dig = 4'd9;
          else begin
            dig   = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
      stepped[4*i +: 4] = dig;
    end
    term    = up ? ALL_NINES : '0;
    at_term = (value == term);
  end

  always_ff @(posedge clk1k or negedge rst) begin
    if (!rst) begin
      value    <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      tick_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        value    <= clamped;
        running  <= 1'b0;
        tick_cnt <= '0;
      end else if (pause) begin
        running <= 1'b0;
      end else if (start && !running) begin
        if (!(at_term && !wrap)) running <= 1'b1;
      end else if (running) begin
        if (tick_cnt == TW'(TICK_DIV - 1)) begin
          tick_cnt <= '0;
          // Already sitting at this direction's terminal (direction flipped): stop in place.
          if (at_term && !wrap) begin
            running <= 1'b0;
            done    <= 1'b1;
          end else begin
            value <= stepped;
            if (stepped == term) begin
              done <= 1'b1;
              if (!wrap) running <= 1'b0;
            end
          end
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk1k or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  logic [DIGITS-1:0] lz;
  logic              zero_run;
  logic [3:0]        shown;
  int                pos;

  // lz[k] marks nibble k as a leading zero; nibble 0 is never blanked.
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run & (value[4*k +: 4] == 4'd0);
      lz[k]    = zero_run;
    end
    pos   = DIGITS - 1 - int'(scan_idx);
    shown = value[4*pos +: 4];
    sel   = ~(DIGITS'(1) << scan_idx);
    if ((BLANK_LZ != 0) && lz[pos]) seg = 8'hFF;
    else begin
      case (shown)
        4'd0:    seg = 8'hC0;
        4'd1:    seg = 8'hF9;
        4'd2:    seg = 8'hA4;
        4'd3:    seg = 8'hB0;
        4'd4:    seg = 8'h99;
        4'd5:    seg = 8'h92;
        4'd6:    seg = 8'h82;
        4'd7:    seg = 8'hF8;
        4'd8:    seg = 8'h80;
        4'd9:    seg = 8'h90;
        default: seg = 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_timer_scan.sv
// Directed bench for bcd_timer_scan: one fast instance (TICK_DIV=1) and one slow (TICK_DIV=1000).
module tb_bcd_timer_scan;

  localparam int D = 6;

  logic           clk1k = 1'b0;
  logic           rst;
  logic           load, start, pause, up, wrap;
  logic [4*D-1:0] load_val;
  logic [4*D-1:0] value, value_s;
  logic           running, running_s, done, done_s;
  logic [D-1:0]   sel, sel_s;
  logic [7:0]     seg, seg_s;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  // clock / reset
  always #5 clk1k = ~clk1k;

  bcd_timer_scan #(.DIGITS(D), .TICK_DIV(1), .SCAN_DIV(1), .BLANK_LZ(1)) dut (
    .rst(rst), .clk1k(clk1k), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .up(up), .wrap(wrap), .value(value), .running(running),
    .done(done), .sel(sel), .seg(seg));

  bcd_timer_scan #(.DIGITS(D), .TICK_DIV(1000), .SCAN_DIV(1), .BLANK_LZ(1)) dut_slow (
    .rst(rst), .clk1k(clk1k), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .up(up), .wrap(wrap), .value(value_s), .running(running_s),
    .done(done_s), .sel(sel_s), .seg(seg_s));

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk1k);
      #1;
    end
  endtask

  task automatic do_load(input logic [4*D-1:0] v);
    load = 1'b1;
    load_val = v;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int found;
    int done_cnt;
    logic [15:0] e;
    rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; up = 1'b0; wrap = 1'b0;
    load_val = '0;
    cyc(2);
    check("rst_value", value, 24'h0);
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sel", sel, 6'h3E);
    check("rst_seg", seg, 8'hFF);
    rst = 1'b1;
    cyc(1);

    // countdown 10 -> 0, stop
    do_load(24'h000010);
    check("t1_load", value, 24'h000010);
    do_start();
    check("t1_running", running, 1'b1);
    cyc(1);
    check("t1_borrow", value, 24'h000009);
    cyc(8);
    check("t1_val1", value, 24'h000001);
    check("t1_nodone", done, 1'b0);
    cyc(1);
    check("t1_zero", value, 24'h0);
    check("t1_done", done, 1'b1);
    check("t1_stopped", running, 1'b0);
    cyc(1);
    check("t1_done_clr", done, 1'b0);
    cyc(3);
    check("t1_hold", value, 24'h0);

    // down with wrap
    wrap = 1'b1; up = 1'b0;
    do_load(24'h009999);
    do_start();
    cyc(9998);
    check("t2_one", value, 24'h000001);
    cyc(1);
    check("t2_zero", value, 24'h0);
    check("t2_done", done, 1'b1);
    check("t2_run_at0", running, 1'b1);
    cyc(1);
    check("t2_wrap", value, 24'h999999);
    check("t2_running", running, 1'b1);
    check("t2_done_clr", done, 1'b0);

    // up with wrap
    up = 1'b1;
    do_load(24'h999998);
    do_start();
    cyc(1);
    check("t2u_term", value, 24'h999999);
    check("t2u_done", done, 1'b1);
    cyc(1);
    check("t2u_wrap", value, 24'h000000);
    check("t2u_done_clr", done, 1'b0);

    // carry, pause, resume
    wrap = 1'b0; up = 1'b1;
    do_load(24'h000009);
    do_start();
    cyc(1);
    check("t3_carry", value, 24'h000010);
    pause = 1'b1;
    cyc(5);
    pause = 1'b0;
    check("t3_pause_val", value, 24'h000010);
    check("t3_pause_run", running, 1'b0);
    do_start();
    cyc(1);
    check("t3_resume", value, 24'h000011);

    // start ignored at terminal
    up = 1'b0;
    do_load(24'h000000);
    do_start();
    check("t4_ignored", running, 1'b0);
    cyc(2);
    check("t4_hold", value, 24'h0);
    check("t4_nodone", done, 1'b0);
    up = 1'b1;
    do_start();
    check("t4_run", running, 1'b1);
    cyc(1);
    check("t4_up", value, 24'h000001);

    // direction flip onto terminal stops in place
    do_load(24'h000000);
    up = 1'b1;
    do_start();
    up = 1'b0;
    cyc(1);
    check("t5_flip_val", value, 24'h0);
    check("t5_flip_done", done, 1'b1);
    check("t5_flip_stop", running, 1'b0);
    cyc(1);
    check("t5_flip_clr", done, 1'b0);

    // clamp and scan
    do_load(24'h0A0305);
    check("t6_clamp", value, 24'h090305);
    found = 0;
    for (int i = 0; i < 2 * D && found == 0; i++) begin
      if (sel == 6'h3E) found = 1;
      else cyc(1);
    end
    check("t6_sync", found, 1);
    repeat (2) begin
      exp_q.push_back({8'h3E, 8'hFF});
      exp_q.push_back({8'h3D, 8'h90});
      exp_q.push_back({8'h3B, 8'hC0});
      exp_q.push_back({8'h37, 8'hB0});
      exp_q.push_back({8'h2F, 8'hC0});
      exp_q.push_back({8'h1F, 8'h92});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("t6_sel", sel, e[15:8]);
      check("t6_seg", seg, e[7:0]);
      cyc(1);
    end

    // slow instance: async reset mid-count
    up = 1'b0; wrap = 1'b0;
    do_load(24'h000003);
    do_start();
    cyc(999);
    check("t7_pre", value_s, 24'h000003);
    cyc(1);
    check("t7_step", value_s, 24'h000002);
    check("t7_running", running_s, 1'b1);
    cyc(500);
    #3;
    rst = 1'b0;
    #1;
    check("t7_rst_val", value_s, 24'h0);
    check("t7_rst_run", running_s, 1'b0);
    check("t7_rst_done", done_s, 1'b0);
    check("t7_rst_sel", sel_s, 6'h3E);
    cyc(2);
    rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      if (done_s) done_cnt++;
    end
    check("t7_no_done", done_cnt, 0);
    check("t7_after_val", value_s, 24'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_timer_scan.md
Name: bcd_timer_scan

Overview:
- Parametrised N-digit BCD timer with integrated multiplexed 7-segment scan driver, clocked from the 1 kHz system tick domain.
- Counts up or down, supports load, start, pause, and stop-or-wrap at the terminal value, and pulses `done` at terminal count.
- Replaces fixed-width countdown-plus-scan logic in board top levels; the top level supplies `clk1k` from the PLL/divider chain.

Parameters:
- DIGITS, 6: number of BCD digits and scan positions (2..8).
- TICK_DIV, 1: clk1k cycles per count step (1..65535); 1 means one step per ms.
- SCAN_DIV, 1: clk1k cycles per scan-position advance (1..255).
- BLANK_LZ, 1: 1 blanks leading zeros; 0 shows all digits.

Ports:
- rst  in  1  asynchronous reset, active-low.
- clk1k  in  1  1 kHz clock; all state updates on its rising edge.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  BCD load value; nibble 0 is the least significant digit.
- start  in  1  begin/resume counting.
- pause  in  1  stop counting and hold value.
- up  in  1  1 counts up, 0 counts down; sampled at every step.
- wrap  in  1  1 wraps at terminal; 0 stops at terminal.
- value  out  4*DIGITS  current BCD count.
- running  out  1  counter active.
- done  out  1  one-cycle pulse at terminal.
- sel  out  DIGITS  active-low one-hot digit select; sel[0] is the leftmost (most significant) digit.
- seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp always 1.

Behaviour:
- Reset (rst=0, async) sets: value=0; running=0; done=0; tick prescaler=0; scan prescaler=0; scan index=0 (sel = all ones except sel[0]=0).
- Priority each cycle is load > pause > start > step.
- Load:
  - value <= load_val with any nibble >9 clamped to 9.
  - running <= 0; tick prescaler <= 0; done <= 0.
- Pause: running <= 0; prescaler holds its current count.
- Start:
  - running <= 1 unless value is terminal and wrap=0; in that case start is ignored.
  - Start while already running has no effect.
  - Terminal value is all-0 when up=0 and all-9 when up=1.
- Step:
  - When running=1, the prescaler counts 0..TICK_DIV-1.
  - On the cycle it equals TICK_DIV-1, it resets to 0 and value steps by 1 in BCD (per-digit borrow/carry 9<->0).
  - The first step after start occurs TICK_DIV cycles after the start cycle.
- Terminal handling:
  - If a step produces the terminal value, done=1 on the same edge that updates value; done is 0 on all other cycles.
  - wrap=0: running <= 0 on that edge; value holds.
  - wrap=1: running stays 1; the next step from all-0 down gives all-9, and from all-9 up gives all-0. done pulses on every arrival at terminal.
- Direction change mid-run:
  - up is sampled at each step.
  - Switching direction while the value sits at the new direction's terminal with wrap=0 stops the counter at the next step. No value change occurs and done pulses.
- Scan:
  - Scan prescaler free-runs 0..SCAN_DIV-1 regardless of running.
  - On wrap of the scan prescaler, the index advances 0..DIGITS-1 and then back to 0.
  - sel[i]=0 exactly when index==i.
  - Digit shown at index i is nibble DIGITS-1-i.
- Segments:
  - seg is combinational from the registered index and value.
  - Encodings: 0=C0h, 1=F9h, 2=A4h, 3=B0h, 4=99h, 5=92h, 6=82h, 7=F8h, 8=80h, 9=90h; blank=FFh.
- Leading-zero blanking (BLANK_LZ=1): a digit is blank if it and all more-significant digits are 0. The least significant digit is never blanked.
- Async reset mid-count or mid-scan returns immediately to the reset state; no done pulse is produced.

Test Plan:
- Reset, then load=1 with load_val=000010h, then start; after 10 clk1k edges, value=000000h, done=1 on exactly that edge, running=0, and value stays 0 thereafter.
- Load 009999h, set wrap=1, up=0, TICK_DIV=1, start, then run 10000 edges; value reaches 0 with done=1, the next edge gives value=999999h, running=1, and done=0.
- Load 000009h, set up=1, start; after one edge value=000010h (carry); then pause for 5 cycles and value holds at 000010h; then start and value=000011h after one edge.
- Load 000000h, set up=0, wrap=0, start; running stays 0 and value stays 0; set up=1 and start; after one edge value=000001h.
- Load 0A0305h: value=090305h; scan with SCAN_DIV=1 shows sel=3Eh, 3Dh, 3Bh, 37h, 2Fh, 1Fh in sequence with seg=FFh (blank), 90h, C0h, B0h, C0h, 92h, then repeats.
- Set TICK_DIV=1000 and load 000003h, start; assert rst low at cycle 1500; value=0, running=0, done=0, and sel=3Eh immediately, with no done pulse afterwards.
